// File: rtl/cmd_pkg.sv
// Shared definitions for the command UART path (sender and receiver).
package cmd_pkg;

    // Byte-sequencing states of the command sender.
    typedef enum logic [1:0] {
        IDLE,
        TX_HI,
        TX_LO
    } sndr_state_t;

    // Start bit + 8 data bits + stop bit.
    localparam int UART_FRAME_BITS    = 10;

    // 50 MHz system clock / 19200 baud.
    localparam int UART_BAUD_DIV_DFLT = 2604;

    // Full 8N1 frame, shifted out LSB first: start(0), data[0..7], stop(1).
    function automatic logic [UART_FRAME_BITS-1:0] uart_frame(input logic [7:0] data);
        return {1'b1, data, 1'b0};
    endfunction

endpackage

// File: rtl/cmd_sender_if.sv
// Command-sender handshake and serial line bundle.
// master: the side issuing commands; slave: cmd_sender itself.
interface cmd_sender_if;
    logic [15:0] cmd;
    logic        snd_cmd;
    logic        TX;
    logic        busy;
    logic        cmd_snt;

    modport master (
        output cmd,
        output snd_cmd,
        input  TX,
        input  busy,
        input  cmd_snt
    );

    modport slave (
        input  cmd,
        input  snd_cmd,
        output TX,
        output busy,
        output cmd_snt
    );
endinterface

// File: rtl/uart_tx.sv
// 8N1 UART transmitter. A trmt pulse loads a full frame and starts it on the
// next cycle; trmt on the tx_done cycle chains a new frame with no idle bit.
module uart_tx
    import cmd_pkg::*;
#(
    parameter int BAUD_DIV = UART_BAUD_DIV_DFLT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       trmt,
    output logic       TX,
    output logic       tx_done
);

    localparam int BW = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;

    logic [BW-1:0]              baud_cnt_reg;
    logic [3:0]                 bit_cnt_reg;
    logic [UART_FRAME_BITS-1:0] shift_reg;
    logic                       active_reg;

    logic baud_last;
    logic bit_last;

    assign baud_last = (baud_cnt_reg == BW'(BAUD_DIV - 1));
    assign bit_last  = (bit_cnt_reg == 4'(UART_FRAME_BITS - 1));
    assign tx_done   = active_reg && baud_last && bit_last;

    // Line idles high whenever no frame is in flight (including during reset).
    assign TX = active_reg ? shift_reg[0] : 1'b1;

    // Baud/bit counters and shift register; a load restarts the frame timing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baud_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
            shift_reg    <= '1;
            active_reg   <= 1'b0;
        end else if (trmt) begin
            baud_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
            shift_reg    <= uart_frame(tx_data);
            active_reg   <= 1'b1;
        end else if (active_reg) begin
            if (baud_last) begin
                baud_cnt_reg <= '0;
                if (bit_last) begin
                    active_reg <= 1'b0;
                end else begin
                    bit_cnt_reg <= bit_cnt_reg + 4'd1;
                    shift_reg   <= {1'b1, shift_reg[UART_FRAME_BITS-1:1]};
                end
            end else begin
                baud_cnt_reg <= baud_cnt_reg + BW'(1);
            end
        end
    end

endmodule

// File: rtl/cmd_sender.sv
// Sends a 16-bit command as two back-to-back 8N1 frames, high byte first.
// Optional feature macro: CMD_SNDR_QUEUE_EN adds a one-deep pending-command
// buffer so a request made while busy follows the current one seamlessly.
module cmd_sender
    import cmd_pkg::*;
#(
    parameter int BAUD_DIV = UART_BAUD_DIV_DFLT
) (
    input  logic         clk,
    input  logic         rst_n,
    cmd_sender_if.slave  bus
);

    sndr_state_t state_reg, state_next;
    logic [15:0] hold_reg,  hold_next;
    logic        cmd_snt_reg, cmd_snt_next;
`ifdef CMD_SNDR_QUEUE_EN
    logic [15:0] pend_reg,     pend_next;
    logic        pend_vld_reg, pend_vld_next;
`endif

    logic       trmt;
    logic [7:0] tx_data;
    logic       tx_done;
    logic       tx_line;

    uart_tx #(
        .BAUD_DIV (BAUD_DIV)
    ) u_uart_tx (
        .clk     (clk),
        .rst_n   (rst_n),
        .tx_data (tx_data),
        .trmt    (trmt),
        .TX      (tx_line),
        .tx_done (tx_done)
    );

    assign bus.TX      = tx_line;
    assign bus.busy    = (state_reg != IDLE);
    assign bus.cmd_snt = cmd_snt_reg;

    // State, holding register(s) and done flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            hold_reg     <= '0;
            cmd_snt_reg  <= 1'b0;
`ifdef CMD_SNDR_QUEUE_EN
            pend_reg     <= '0;
            pend_vld_reg <= 1'b0;
`endif
        end else begin
            state_reg    <= state_next;
            hold_reg     <= hold_next;
            cmd_snt_reg  <= cmd_snt_next;
`ifdef CMD_SNDR_QUEUE_EN
            pend_reg     <= pend_next;
            pend_vld_reg <= pend_vld_next;
`endif
        end
    end

    // Byte sequencing: the transmitter is (re)triggered combinationally so the
    // start bit begins right after the accepting edge and frames chain gap-free.
    always_comb begin
        state_next   = state_reg;
        hold_next    = hold_reg;
        cmd_snt_next = cmd_snt_reg;
        trmt         = 1'b0;
        tx_data      = 8'h00;
`ifdef CMD_SNDR_QUEUE_EN
        pend_next     = pend_reg;
        pend_vld_next = pend_vld_reg;
`endif

        case (state_reg)
            IDLE: begin
                if (bus.snd_cmd) begin
                    hold_next    = bus.cmd;
                    cmd_snt_next = 1'b0;
                    trmt         = 1'b1;
                    tx_data      = bus.cmd[15:8];
                    state_next   = TX_HI;
                end
            end

            TX_HI: begin
                if (tx_done) begin
                    trmt       = 1'b1;
                    tx_data    = hold_reg[7:0];
                    state_next = TX_LO;
                end
`ifdef CMD_SNDR_QUEUE_EN
                if (bus.snd_cmd && !pend_vld_reg) begin
                    pend_next     = bus.cmd;
                    pend_vld_next = 1'b1;
                end
`endif
            end

            TX_LO: begin
                if (tx_done) begin
`ifdef CMD_SNDR_QUEUE_EN
                    if (pend_vld_reg) begin
                        // Buffered word goes next; a request this cycle sees a full buffer.
                        hold_next     = pend_reg;
                        pend_vld_next = 1'b0;
                        trmt          = 1'b1;
                        tx_data       = pend_reg[15:8];
                        state_next    = TX_HI;
                    end else
`endif
                    if (bus.snd_cmd) begin
                        // Accept on the completion edge: clear wins over set.
                        hold_next    = bus.cmd;
                        cmd_snt_next = 1'b0;
                        trmt         = 1'b1;
                        tx_data      = bus.cmd[15:8];
                        state_next   = TX_HI;
                    end else begin
                        cmd_snt_next = 1'b1;
                        state_next   = IDLE;
                    end
                end
`ifdef CMD_SNDR_QUEUE_EN
                else if (bus.snd_cmd && !pend_vld_reg) begin
                    pend_next     = bus.cmd;
                    pend_vld_next = 1'b1;
                end
`endif
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cmd_sender.sv
// Self-checking bench for cmd_sender with BAUD_DIV=8. The expected line level
// for every cycle is derived from the command words via frame arithmetic.
module tb_cmd_sender;

    localparam int B  = 8;
    localparam int CW = 20 * B;   // cycles per command
`ifdef CMD_SNDR_QUEUE_EN
    localparam int QEN = 1;
`else
    localparam int QEN = 0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    cmd_sender_if bus();

    cmd_sender #(
        .BAUD_DIV (B)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input string sig, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s.%s observed=%b expected=%b", tag, sig, obs, exp);
        end
    endtask

    // Expected line level during bit slot i (0..19) of a command w.
    function automatic logic line_bit(input logic [15:0] w, input int i);
        int         f;
        int         j;
        logic [7:0] b;
        f = i / 10;
        j = i % 10;
        b = (f == 0) ? w[15:8] : w[7:0];
        if (j == 0) return 1'b0;
        if (j == 9) return 1'b1;
        return b[j-1];
    endfunction

    // Request w0 at edge 0, optionally pulse snd_cmd again at cycle inj_c, and
    // check n_exp commands (w0 then w1) go out back to back, then an idle tail.
    task automatic run_seq(input string tag, input logic [15:0] w0, input int inj_c,
                           input logic [15:0] inj_w, input int n_exp,
                           input logic [15:0] w1, input int idle_after,
                           output logic [39:0] mids);
        logic [15:0] ew [2];
        ew[0] = w0;
        ew[1] = w1;
        mids  = '0;
        @(negedge clk);
        bus.cmd     = w0;
        bus.snd_cmd = 1'b1;
        for (int c = 1; c <= n_exp * CW; c++) begin
            @(negedge clk);
            bus.snd_cmd = (c == inj_c);
            bus.cmd     = (c == inj_c) ? inj_w : 16'($urandom);
            chk(tag, "tx",   bus.TX, line_bit(ew[(c-1)/CW], ((c-1) % CW) / B));
            chk(tag, "busy", bus.busy, 1'b1);
            chk(tag, "snt",  bus.cmd_snt, 1'b0);
            if ((c % B) == B/2) mids[(c-1)/B] = bus.TX;
        end
        for (int c = 0; c <= idle_after; c++) begin
            @(negedge clk);
            bus.snd_cmd = 1'b0;
            chk(tag, "idle_tx",   bus.TX, 1'b1);
            chk(tag, "idle_busy", bus.busy, 1'b0);
            chk(tag, "idle_snt",  bus.cmd_snt, 1'b1);
        end
    endtask

    initial begin
        logic [39:0] mids;
        logic [19:0] exp_mid;
        logic [15:0] w;
        logic [15:0] iw;
        int          ic;
        int          nx;

        bus.cmd     = 16'h0000;
        bus.snd_cmd = 1'b0;

        // Reset held, then 100 quiet cycles
        repeat (3) @(negedge clk);
        chk("rst", "tx", bus.TX, 1'b1);
        chk("rst", "busy", bus.busy, 1'b0);
        chk("rst", "snt", bus.cmd_snt, 1'b0);
        rst_n = 1'b1;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            bus.cmd = 16'($urandom);
            chk("quiet", "tx", bus.TX, 1'b1);
            chk("quiet", "busy", bus.busy, 1'b0);
            chk("quiet", "snt", bus.cmd_snt, 1'b0);
        end

        // A5C3 with mid-bit samples against the literal frame pattern
        run_seq("a5c3", 16'hA5C3, 0, 16'h0000, 1, 16'h0000, 4, mids);
        exp_mid = 20'b1110_0001_1011_0100_1010;
        for (int i = 0; i < 20; i++) chk("a5c3_mid", $sformatf("bit%0d", i), mids[i], exp_mid[i]);
        $display("txn a5c3 sent=%h", 16'hA5C3);

        // Request during busy at cycle 50: dropped, or buffered when queued
        nx = (QEN != 0) ? 2 : 1;
        run_seq("beef", 16'h00FF, 50, 16'hBEEF, nx, 16'hBEEF, CW, mids);
        $display("txn 00ff + beef@50 commands_expected=%0d", nx);

        // Request on the completion edge chains directly, flag stays clear
        run_seq("done_edge", 16'h3C96, CW, 16'h0101, 2, 16'h0101, 3, mids);
        $display("txn 3c96 + 0101@done");

        // Asynchronous reset in the middle of the high-byte frame
        @(negedge clk);
        bus.cmd     = 16'h0000;
        bus.snd_cmd = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            bus.snd_cmd = 1'b0;
            bus.cmd     = 16'($urandom);
        end
        chk("midrst", "pre_tx", bus.TX, 1'b0);
        chk("midrst", "pre_busy", bus.busy, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst", "tx", bus.TX, 1'b1);
        chk("midrst", "busy", bus.busy, 1'b0);
        chk("midrst", "snt", bus.cmd_snt, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        run_seq("after_rst", 16'h5A5A, 0, 16'h0000, 1, 16'h0000, 2, mids);
        $display("txn reset@40 then 5a5a");

        // Randomized commands, some with a mid-command request
        for (int i = 0; i < 6; i++) begin
            w  = 16'($urandom);
            iw = 16'($urandom);
            ic = ($urandom % 2 == 0) ? 0 : $urandom_range(2, CW - 1);
            nx = (ic != 0 && QEN != 0) ? 2 : 1;
            run_seq("rand", w, ic, iw, nx, iw, $urandom_range(0, 5), mids);
            $display("txn rand cmd=%h inj_cycle=%0d inj=%h commands_expected=%0d", w, ic, iw, nx);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cmd_sender.md
# cmd_sender

Transmit-side counterpart of the command-processor UART path. Accepts a 16-bit command word and serialises it onto a single TX line as two 8N1 UART frames, high byte first. The receiving UART wrapper reassembles them into `cmd`/`cmd_rdy`. It sits in the remote/controller side of the design and in the top-level test bench, where its TX drives the follower's RX.

## Interface
- `BAUD_DIV`, default 2604: clocks per UART bit (50 MHz / 19200 baud). Legal minimum is 2.
- `clk` input, 1 bit: system clock. All logic is on the rising edge.
- `rst_n` input, 1 bit: reset, asynchronous, active-low.
- `cmd` input, 16 bits: command word. Sampled only on the cycle `snd_cmd` is accepted.
- `snd_cmd` input, 1 bit: one-cycle request to send `cmd`.
- `TX` output, 1 bit: serial line. Idles high.
- `busy` output, 1 bit: high while a command is being transmitted.
- `cmd_snt` output, 1 bit: sticky done flag.

## Operation
- Reset values: `TX`=1, `busy`=0, `cmd_snt`=0. The holding register, counters and FSM are all cleared.
- Accept rule: `snd_cmd`=1 while `busy`=0.
  - `cmd` is captured into a 16-bit holding register.
  - `busy` goes to 1 and `cmd_snt` is cleared.
- FSM states:
  - IDLE: on accept, go to TX_HI.
  - TX_HI: transmit `cmd[15:8]`. On frame done, go to TX_LO.
  - TX_LO: transmit `cmd[7:0]`. On frame done, set `cmd_snt`, clear `busy`, go to IDLE.
- Frame format: 10 bits, each exactly `BAUD_DIV` clocks long.
  - Start bit (0).
  - Data bits 0..7, LSB first.
  - Stop bit (1).
- Bit timing:
  - Baud counter counts 0..`BAUD_DIV`-1. It is reloaded at frame start and on each bit boundary.
  - 4-bit bit counter counts 0..9.
  - Frame done occurs when the bit counter equals 9 and the baud counter equals `BAUD_DIV`-1.
- `cmd_snt` stays high until the next accepted `snd_cmd`.
- `snd_cmd` while `busy`=1 is ignored: no capture and no flag change. See Configuration for the buffered variant.
- Changes to `cmd` after capture have no effect.
- Reset asserted mid-frame: `TX` returns high immediately (asynchronous) and the partial frame is abandoned. After release, the first `snd_cmd` is accepted normally.

## Timing
- `snd_cmd` sampled high at edge 0: `TX` falls after edge 0, so the start bit occupies cycles 1..`BAUD_DIV`.
- The low-byte start bit begins the cycle after the high-byte stop bit ends. There are zero idle cycles between the two frames.
- Whole command: 20×`BAUD_DIV` cycles of line activity.
- At edge 20×`BAUD_DIV`, `cmd_snt` rises and `busy` falls, both in the same cycle.
- A new `snd_cmd` may be accepted on that same edge. Back-to-back commands leave no idle gap.
- Accepting `snd_cmd` in the same cycle as completion clears `cmd_snt`: clear wins over set.

## Configuration
- `CMD_SNDR_QUEUE_EN`: adds a one-deep pending-command buffer.
- Defined:
  - `snd_cmd` while `busy`=1 and the buffer is empty stores `cmd` in the buffer.
  - When the current TX_LO frame completes, the buffered word moves to the holding register and TX_HI starts the next cycle, with zero idle bits.
  - `busy` stays high throughout.
  - `cmd_snt` is set only when a command completes with the buffer empty.
  - `snd_cmd` with the buffer full is ignored.
  - `snd_cmd` in the completion cycle with the buffer empty is accepted directly, as without the macro.
- Not defined: no buffer. `snd_cmd` while busy is dropped.
- The port list is identical in both builds.

## Structure
- Package `cmd_pkg`:
  - `sndr_state_t` enum (IDLE, TX_HI, TX_LO).
  - `UART_FRAME_BITS`=10.
  - `UART_BAUD_DIV_DFLT`=2604.
  - Both sender and receiver share this package.
- Sub-module `uart_tx`, one instance:
  - Ports: `clk`, `rst_n`, `tx_data`[7:0], `trmt`, `TX`, `tx_done`.
  - Owns the baud counter, bit counter and 10-bit shift register.
  - `cmd_sender` owns the byte-sequencing FSM, holding register(s) and flags.

## Test plan
- Reset only: `TX`=1, `busy`=0, `cmd_snt`=0 for 100 cycles. `snd_cmd` held 0 gives no line activity.
- `BAUD_DIV`=8, `cmd`=16'hA5C3, one-cycle `snd_cmd`:
  - `TX` sampled mid-bit shows 0,1,0,1,0,0,1,0,1,1 then 0,1,1,0,0,0,0,1,1,1.
  - `cmd_snt` rises exactly 160 cycles after the request edge, with `busy` falling the same cycle.
- Loopback `TX` into UART_wrapper RX, `BAUD_DIV`=2604, `cmd`=16'h1234: receiver `cmd_rdy` pulses with `cmd`=16'h1234.
- `BAUD_DIV`=8, send 16'h00FF. At cycle 50, pulse `snd_cmd` with `cmd`=16'hBEEF.
  - Without the macro: only 00FF is sent and the line is idle after cycle 160.
  - With `CMD_SNDR_QUEUE_EN`: BEEF follows immediately. `busy` stays high for 320 cycles and `cmd_snt` rises once, at cycle 320.
- `BAUD_DIV`=8, assert `rst_n`=0 at cycle 40 of a send:
  - `TX`=1, `busy`=0, `cmd_snt`=0 asynchronously.
  - After release, 16'h5A5A transmits correctly.
- Completion-edge request, `BAUD_DIV`=8: `snd_cmd` with 16'h0101 on the done edge starts the next start bit at once, and `cmd_snt` stays 0.
